// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the instruction-cache family.
// Line layout helpers describe a packed {valid, tag, data} line for later variants.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    INVAL  = 2'd3
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_w(input int sets);
    return clog2_min1(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 30 - idx_w(sets);
  endfunction

  function automatic int age_w(input int ways);
    return clog2_min1(ways);
  endfunction

  // Packed line: data in the low bits, tag above it, valid on top.
  function automatic int line_data_lsb();
    return 0;
  endfunction

  function automatic int line_tag_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int line_valid_bit(input int data_w, input int sets);
    return data_w + tag_w(sets);
  endfunction

  function automatic int line_w(input int data_w, input int sets);
    return data_w + tag_w(sets) + 1;
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU ages for one set: promotes the accessed way to age 0 and picks the victim.
// Purely combinational; victim is the lowest invalid way, else the oldest way.
module cache_lru_set #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS*AGE_W-1:0] ages,
  input  logic [WAYS-1:0]       valid,
  input  logic [AGE_W-1:0]      acc_way,
  output logic [WAYS*AGE_W-1:0] ages_upd,
  output logic [AGE_W-1:0]      victim
);

  logic [AGE_W-1:0] acc_age;
  logic             found;

  always_comb begin
    acc_age  = ages[acc_way*AGE_W +: AGE_W];
    ages_upd = ages;
    victim   = '0;
    found    = 1'b0;

    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end

    // Ways younger than the accessed one age by one, keeping ages a permutation.
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == acc_way)
        ages_upd[w*AGE_W +: AGE_W] = '0;
      else if (ages[w*AGE_W +: AGE_W] < acc_age)
        ages_upd[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W] + AGE_W'(1);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative one-word-line I-cache with true LRU and a memory fill handshake.
// Hit: data two edges after REQ; miss holds MM_REQ until MM_VALID; REQ/INVALIDATE ignored while BUSY.
module cache_nway
  import cache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic [31:0]       PC,
  input  logic              INVALIDATE,
  output logic              BUSY,
  output logic              HIT,
  output logic              DATA_VALID,
  output logic [DATA_W-1:0] DATA_CACHE,
  output logic              MM_REQ,
  output logic [31:0]       MM_ADDR,
  input  logic              MM_VALID,
  input  logic [DATA_W-1:0] MM_DATA,
  output logic [CNT_W-1:0]  CNT_HIT,
  output logic [CNT_W-1:0]  CNT_MISS
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS);
  localparam int AGE_W = age_w(WAYS);

  state_t state_q, state_d;

  logic [29:0]            word_addr_q;
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS*AGE_W-1:0]  age_q   [SETS];
  logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]      data_q  [SETS][WAYS];

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic [AGE_W-1:0]       hit_way, acc_way, victim;
  logic [WAYS*AGE_W-1:0]  ages_upd;
  logic                   unused_pc_lsb;

  assign unused_pc_lsb = ^PC[1:0];
  assign idx  = word_addr_q[IDX_W-1:0];
  assign tag  = word_addr_q[29:IDX_W];
  assign BUSY = (state_q != IDLE);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  assign acc_way = (state_q == FILL) ? victim : hit_way;

  cache_lru_set #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages     (age_q[idx]),
    .valid    (valid_q[idx]),
    .acc_way  (acc_way),
    .ages_upd (ages_upd),
    .victim   (victim)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (INVALIDATE)  state_d = INVAL;
        else if (REQ)    state_d = LOOKUP;
      end
      LOOKUP:  state_d = hit ? IDLE : FILL;
      FILL:    if (MM_VALID) state_d = IDLE;
      INVAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      HIT         <= 1'b0;
      DATA_VALID  <= 1'b0;
      DATA_CACHE  <= '0;
      MM_REQ      <= 1'b0;
      MM_ADDR     <= '0;
      CNT_HIT     <= '0;
      CNT_MISS    <= '0;
      word_addr_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      HIT        <= 1'b0;
      DATA_VALID <= 1'b0;
      case (state_q)
        IDLE: if (!INVALIDATE && REQ) word_addr_q <= PC[31:2];
        INVAL: for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        LOOKUP: begin
          if (hit) begin
            DATA_CACHE <= data_q[idx][hit_way];
            HIT        <= 1'b1;
            DATA_VALID <= 1'b1;
            age_q[idx] <= ages_upd;
            if (~&CNT_HIT) CNT_HIT <= CNT_HIT + CNT_W'(1);
          end else begin
            MM_REQ  <= 1'b1;
            MM_ADDR <= {word_addr_q, 2'b00};
            if (~&CNT_MISS) CNT_MISS <= CNT_MISS + CNT_W'(1);
          end
        end
        FILL: begin
          if (MM_VALID) begin
            valid_q[idx][victim] <= 1'b1;
            age_q[idx]           <= ages_upd;
            DATA_CACHE           <= MM_DATA;
            DATA_VALID           <= 1'b1;
            MM_REQ               <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (RESET && state_q == FILL && MM_VALID) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= MM_DATA;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway (WAYS=2, SETS=4, CNT_W=4) with a response scoreboard.
module tb_cache_nway;

  logic        CLK = 1'b0;
  logic        RESET, REQ, INVALIDATE, MM_VALID;
  logic [31:0] PC, MM_DATA;
  logic        BUSY, HIT, DATA_VALID, MM_REQ;
  logic [31:0] DATA_CACHE, MM_ADDR;
  logic [3:0]  CNT_HIT, CNT_MISS;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_hit   = 0;
  int   m_miss  = 0;

  cache_nway #(.WAYS(2), .SETS(4), .DATA_W(32), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .PC(PC), .INVALIDATE(INVALIDATE),
    .BUSY(BUSY), .HIT(HIT), .DATA_VALID(DATA_VALID), .DATA_CACHE(DATA_CACHE),
    .MM_REQ(MM_REQ), .MM_ADDR(MM_ADDR), .MM_VALID(MM_VALID), .MM_DATA(MM_DATA),
    .CNT_HIT(CNT_HIT), .CNT_MISS(CNT_MISS)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, " cnt_hit"},  {28'd0, CNT_HIT},  m_hit);
    check({tag, " cnt_miss"}, {28'd0, CNT_MISS}, m_miss);
  endtask

  // One fetch; on a miss memory answers with 'word' after 'delay' cycles, on a hit 'word' is expected.
  task automatic fetch(input string tag, input logic [31:0] pc, input bit exp_hit,
                       input logic [31:0] word, input int delay);
    exp_t e;
    sb_q.push_back('{hit: exp_hit, data: word});
    check({tag, " idle"}, {31'd0, BUSY}, 32'd0);
    REQ = 1'b1;
    PC  = pc;
    tick();
    REQ = 1'b0;
    PC  = 32'hFFFF_FFFF;
    check({tag, " busy"}, {31'd0, BUSY}, 32'd1);
    tick();
    if (exp_hit) begin
      if (m_hit < 15) m_hit++;
      check({tag, " mm_req"}, {31'd0, MM_REQ}, 32'd0);
    end else begin
      if (m_miss < 15) m_miss++;
      check({tag, " mm_req"},  {31'd0, MM_REQ}, 32'd1);
      check({tag, " mm_addr"}, MM_ADDR, {pc[31:2], 2'b00});
      for (int i = 0; i < delay; i++) tick();
      MM_VALID = 1'b1;
      MM_DATA  = word;
      tick();
      MM_VALID = 1'b0;
      MM_DATA  = 32'h0;
      check({tag, " mm_req_drop"}, {31'd0, MM_REQ}, 32'd0);
    end
    check({tag, " data_valid"}, {31'd0, DATA_VALID}, 32'd1);
    if (DATA_VALID === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " hit"},  {31'd0, HIT}, {31'd0, e.hit});
      check({tag, " data"}, DATA_CACHE,  e.data);
    end
    check_counters(tag);
  endtask

  initial begin
    RESET = 1'b0; REQ = 1'b0; INVALIDATE = 1'b0; MM_VALID = 1'b0;
    PC = 32'h0; MM_DATA = 32'h0;
    tick(); tick();
    RESET = 1'b1;
    check("rst busy",     {31'd0, BUSY},       32'd0);
    check("rst hit",      {31'd0, HIT},        32'd0);
    check("rst dv",       {31'd0, DATA_VALID}, 32'd0);
    check("rst mm_req",   {31'd0, MM_REQ},     32'd0);
    check("rst mm_addr",  MM_ADDR,             32'd0);
    check("rst data",     DATA_CACHE,          32'd0);
    check_counters("rst");

    fetch("miss10",   32'h10, 1'b0, 32'hDEADBEEF, 3);
    tick();
    check("dv pulse",   {31'd0, DATA_VALID}, 32'd0);
    check("data hold",  DATA_CACHE,          32'hDEADBEEF);
    fetch("hit10",    32'h10, 1'b1, 32'hDEADBEEF, 0);
    fetch("miss30",   32'h30, 1'b0, 32'h3030_0001, 0);
    fetch("hit10b",   32'h10, 1'b1, 32'hDEADBEEF, 0);
    fetch("miss50",   32'h50, 1'b0, 32'h5050_0002, 2);
    fetch("hit10c",   32'h10, 1'b1, 32'hDEADBEEF, 0);
    fetch("evict30",  32'h33, 1'b0, 32'h3030_0003, 1);
    fetch("miss14",   32'h14, 1'b0, 32'h1414_0004, 0);
    fetch("hit14",    32'h14, 1'b1, 32'h1414_0004, 0);

    // INVALIDATE wins over a simultaneous REQ that would otherwise hit.
    INVALIDATE = 1'b1; REQ = 1'b1; PC = 32'h10;
    tick();
    INVALIDATE = 1'b0; REQ = 1'b0;
    check("inval busy",   {31'd0, BUSY},       32'd1);
    tick();
    check("inval done",   {31'd0, BUSY},       32'd0);
    check("inval no dv",  {31'd0, DATA_VALID}, 32'd0);
    check("inval no mm",  {31'd0, MM_REQ},     32'd0);
    fetch("inv10",    32'h10, 1'b0, 32'hA000_0010, 0);
    fetch("inv30",    32'h30, 1'b0, 32'hA000_0030, 0);
    fetch("inv14",    32'h14, 1'b0, 32'hA000_0014, 0);

    // Reset during FILL aborts the miss; a late MM_VALID is ignored.
    REQ = 1'b1; PC = 32'h70;
    tick();
    REQ = 1'b0;
    tick();
    check("abort mm_req", {31'd0, MM_REQ}, 32'd1);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    m_hit = 0; m_miss = 0;
    check("abort mm_low", {31'd0, MM_REQ}, 32'd0);
    check_counters("abort");
    MM_VALID = 1'b1; MM_DATA = 32'hBAD0_BAD0;
    tick();
    MM_VALID = 1'b0;
    check("late no dv",   {31'd0, DATA_VALID}, 32'd0);
    check("late idle",    {31'd0, BUSY},       32'd0);
    tick();
    check("late no dv2",  {31'd0, DATA_VALID}, 32'd0);
    fetch("post70",   32'h70, 1'b0, 32'h7070_0070, 0);
    fetch("post10",   32'h10, 1'b0, 32'hB000_0010, 1);

    for (int i = 0; i < 15; i++)
      fetch("sat", 32'h200 + 32'(i) * 32'h40, 1'b0, 32'hC000_0000 + 32'(i), i % 3);
    check("sat stick",    {28'd0, CNT_MISS}, 32'd15);
    fetch("sat hit",  32'h200 + 32'd14 * 32'h40, 1'b1, 32'hC000_000E, 0);
    check("sat after hit", {28'd0, CNT_MISS}, 32'd15);
    check("sb empty",     sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
